// File: rtl/pulse_seq_ctrl_if.sv
// Bundles the sequencer's config/status bus and the sigpulse-facing strobes.
// slave: the sequencer side. master: the host plus sigpulse side.
interface pulse_seq_ctrl_if #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) ();
  logic                 start;
  logic                 abort;
  logic [RAM_WIDTH-1:0] cfg_delay;
  logic [RAM_WIDTH-1:0] cfg_width;
  logic [RAM_WIDTH-1:0] cfg_gap;
  logic [CNT_WIDTH-1:0] cfg_count;
  logic                 cfg_level;
  logic                 sp_en;
  logic                 sp_dis;
  logic [RAM_WIDTH-1:0] sp_width;
  logic                 sp_level;
  logic                 sp_valid;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic                 err;
  logic [CNT_WIDTH-1:0] pulses_sent;

  modport slave (
    input  start, abort, cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_level, sp_valid,
    output sp_en, sp_dis, sp_width, sp_level, busy, done, aborted, err, pulses_sent
  );

  modport master (
    output start, abort, cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_level, sp_valid,
    input  sp_en, sp_dis, sp_width, sp_level, busy, done, aborted, err, pulses_sent
  );
endinterface

// File: rtl/pulse_seq_ctrl.sv
// Burst sequencer for one sigpulse instance: start delay, then N pulses of
// width W separated by gap G, with abort and a per-pulse watchdog.
module pulse_seq_ctrl #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic              io_clk,
  input  logic              io_rst,
  pulse_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    FIRE,
    WAIT,
    GAP,
    ABORT,
    DONE
  } state_t;

  state_t               r_state;
  logic [RAM_WIDTH-1:0] r_cnt;
  logic [RAM_WIDTH-1:0] r_gap;
  logic [RAM_WIDTH-1:0] r_width;
  logic [RAM_WIDTH:0]   r_wdog;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_sent;
  logic                 r_level;
  logic                 r_err;
  logic                 r_aborted;

  logic [RAM_WIDTH:0]   w_wdog_next;
  logic [RAM_WIDTH:0]   w_wdog_limit;
  logic [CNT_WIDTH-1:0] w_sent_next;
  logic                 w_bad_cfg;
  logic                 w_abort_hit;

  // Watchdog is one bit wider than W so W+4 cannot wrap.
  assign w_wdog_next  = r_wdog + (RAM_WIDTH+1)'(1);
  assign w_wdog_limit = {1'b0, r_width} + (RAM_WIDTH+1)'(4);
  assign w_sent_next  = r_sent + CNT_WIDTH'(1);
  assign w_bad_cfg    = (bus.cfg_width == '0) || (bus.cfg_count == '0);
  assign w_abort_hit  = bus.abort &&
                        ((r_state == DELAY) || (r_state == FIRE) ||
                         (r_state == WAIT)  || (r_state == GAP));

  // Strobes decode directly from the state register; reset (IDLE) forces them low.
  assign bus.sp_en       = (r_state == FIRE);
  assign bus.sp_dis      = (r_state == ABORT);
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.sp_width    = r_width;
  assign bus.sp_level    = r_level;
  assign bus.err         = r_err;
  assign bus.aborted     = r_aborted;
  assign bus.pulses_sent = r_sent;

  // Burst state machine with config latches, countdown, watchdog and status.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_width   <= '0;
      r_wdog    <= '0;
      r_count   <= '0;
      r_sent    <= '0;
      r_level   <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
    end else if (w_abort_hit) begin
      // Abort outranks sp_valid and countdown expiry in the same cycle.
      r_aborted <= 1'b1;
      r_state   <= ABORT;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_bad_cfg) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_width   <= bus.cfg_width;
              r_gap     <= bus.cfg_gap;
              r_count   <= bus.cfg_count;
              r_level   <= bus.cfg_level;
              r_cnt     <= bus.cfg_delay;
              r_sent    <= '0;
              r_err     <= 1'b0;
              r_aborted <= 1'b0;
              r_state   <= DELAY;
            end
          end
        end
        DELAY, GAP: begin
          if (r_cnt == '0) begin
            r_state <= FIRE;
          end else begin
            r_cnt <= r_cnt - RAM_WIDTH'(1);
          end
        end
        FIRE: begin
          r_wdog  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.sp_valid) begin
            r_sent <= w_sent_next;
            if (w_sent_next == r_count) begin
              r_state <= DONE;
            end else begin
              r_cnt   <= r_gap;
              r_state <= GAP;
            end
          end else begin
            r_wdog <= w_wdog_next;
            if (w_wdog_next == w_wdog_limit) begin
              r_err     <= 1'b1;
              r_aborted <= 1'b1;
              r_state   <= ABORT;
            end
          end
        end
        ABORT:   r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl with a behavioural sigpulse responder and
// a cycle-stamped scoreboard for sp_en, sp_dis and done.
module tb_pulse_seq_ctrl;

  logic io_clk;
  logic io_rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   cur_w;
  logic tie_low;
  int   vdly;
  int   c0;

  int exp_en[$];
  int exp_dis[$];
  int exp_done[$];

  pulse_seq_ctrl_if #(.RAM_WIDTH(32), .CNT_WIDTH(16)) bus ();

  pulse_seq_ctrl #(.RAM_WIDTH(32), .CNT_WIDTH(16)) dut (
    .io_clk (io_clk),
    .io_rst (io_rst),
    .bus    (bus)
  );

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  always @(posedge io_clk) cyc <= cyc + 1;

  // sigpulse responder: pulse_valid W+2 cycles after io_en, one cycle after pwm_dis.
  always @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      vdly         <= 0;
      bus.sp_valid <= 1'b0;
    end else begin
      if (bus.sp_en && !tie_low) vdly <= cur_w + 1;
      else if (vdly != 0)        vdly <= vdly - 1;
      bus.sp_valid <= (vdly == 1) || bus.sp_dis;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: each strobe must match the next expected cycle stamp.
  always @(negedge io_clk) begin
    if (!io_rst) begin
      if (bus.sp_en) begin
        if (exp_en.size() == 0) chk("sp_en_spurious", bus.sp_en, 0);
        else                    chk("sp_en_cycle", cyc, exp_en.pop_front());
      end
      if (bus.sp_dis) begin
        if (exp_dis.size() == 0) chk("sp_dis_spurious", bus.sp_dis, 0);
        else                     chk("sp_dis_cycle", cyc, exp_dis.pop_front());
      end
      if (bus.done) begin
        if (exp_done.size() == 0) chk("done_spurious", bus.done, 0);
        else                      chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge io_clk);
  endtask

  task automatic drive_start(input int d, input int w, input int g, input int n, input logic lvl);
    bus.cfg_delay = d;
    bus.cfg_width = w;
    bus.cfg_gap   = g;
    bus.cfg_count = n[15:0];
    bus.cfg_level = lvl;
    cur_w         = w;
    bus.start     = 1'b1;
    c0            = cyc;
  endtask

  task automatic drop_start();
    @(negedge io_clk);
    bus.start = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_en_left"},   exp_en.size(),   0);
    chk({tag, "_dis_left"},  exp_dis.size(),  0);
    chk({tag, "_done_left"}, exp_done.size(), 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; cur_w = 0; tie_low = 1'b0;
    io_rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0;
    bus.cfg_count = '0; bus.cfg_level = 1'b0;
    repeat (3) @(negedge io_clk);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_en",    bus.sp_en, 0);
    chk("rst_dis",   bus.sp_dis, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_err",   bus.err, 0);
    chk("rst_abt",   bus.aborted, 0);
    chk("rst_width", bus.sp_width, 0);
    chk("rst_sent",  bus.pulses_sent, 0);
    io_rst = 1'b0;
    repeat (2) @(negedge io_clk);

    // Basic burst D=2 W=3 G=1 N=2.
    drive_start(2, 3, 1, 2, 1'b0);
    exp_en.push_back(c0 + 4); exp_en.push_back(c0 + 12);
    exp_done.push_back(c0 + 18);
    drop_start();
    chk("b1_busy", bus.busy, 1);
    wait_cyc(c0 + 5);
    chk("b1_width", bus.sp_width, 3);
    chk("b1_level", bus.sp_level, 0);
    wait_cyc(c0 + 18);
    chk("b1_busy_done", bus.busy, 1);
    wait_cyc(c0 + 19);
    chk("b1_idle", bus.busy, 0);
    chk("b1_sent", bus.pulses_sent, 2);
    chk("b1_err",  bus.err, 0);
    chk("b1_abt",  bus.aborted, 0);
    wait_cyc(c0 + 22);
    check_drained("b1");

    // Tight burst D=0 W=1 G=0 N=3: sp_en spacing of 5.
    drive_start(0, 1, 0, 3, 1'b1);
    exp_en.push_back(c0 + 2); exp_en.push_back(c0 + 7); exp_en.push_back(c0 + 12);
    exp_done.push_back(c0 + 16);
    drop_start();
    wait_cyc(c0 + 3);
    chk("b2_level", bus.sp_level, 1);
    wait_cyc(c0 + 18);
    chk("b2_sent", bus.pulses_sent, 3);
    check_drained("b2");

    // Abort during WAIT.
    drive_start(2, 3, 1, 2, 1'b0);
    exp_en.push_back(c0 + 4);
    exp_dis.push_back(c0 + 7);
    exp_done.push_back(c0 + 8);
    drop_start();
    wait_cyc(c0 + 6);
    bus.abort = 1'b1;
    @(negedge io_clk);
    bus.abort = 1'b0;
    wait_cyc(c0 + 9);
    chk("ab_idle", bus.busy, 0);
    wait_cyc(c0 + 30);
    chk("ab_abt",  bus.aborted, 1);
    chk("ab_err",  bus.err, 0);
    chk("ab_sent", bus.pulses_sent, 0);
    check_drained("ab");

    // Bad config: zero width, then zero count.
    drive_start(1, 0, 1, 2, 1'b0);
    exp_done.push_back(c0 + 1);
    drop_start();
    chk("bw_err", bus.err, 1);
    wait_cyc(c0 + 6);
    chk("bw_idle", bus.busy, 0);
    drive_start(1, 2, 1, 0, 1'b0);
    exp_done.push_back(c0 + 1);
    drop_start();
    chk("bn_err", bus.err, 1);
    wait_cyc(c0 + 6);
    check_drained("bad");

    // Watchdog timeout: sp_valid never returns, W=3.
    tie_low = 1'b1;
    drive_start(0, 3, 0, 1, 1'b0);
    exp_en.push_back(c0 + 2);
    exp_dis.push_back(c0 + 10);
    exp_done.push_back(c0 + 11);
    drop_start();
    wait_cyc(c0 + 9);
    chk("wd_busy", bus.busy, 1);
    wait_cyc(c0 + 12);
    chk("wd_err", bus.err, 1);
    chk("wd_abt", bus.aborted, 1);
    check_drained("wd");
    tie_low = 1'b0;
    wait_cyc(c0 + 15);

    // Reset while in GAP, then start with abort in the same cycle.
    drive_start(2, 3, 4, 2, 1'b1);
    exp_en.push_back(c0 + 4);
    drop_start();
    wait_cyc(c0 + 11);
    chk("rg_busy_pre", bus.busy, 1);
    io_rst = 1'b1;
    exp_en.delete(); exp_dis.delete(); exp_done.delete();
    #1;
    chk("rg_busy",  bus.busy, 0);
    chk("rg_width", bus.sp_width, 0);
    chk("rg_level", bus.sp_level, 0);
    chk("rg_sent",  bus.pulses_sent, 0);
    chk("rg_dis",   bus.sp_dis, 0);
    @(negedge io_clk);
    io_rst = 1'b0;
    @(negedge io_clk);
    drive_start(1, 2, 0, 2, 1'b0);
    bus.abort = 1'b1;
    exp_en.push_back(c0 + 3); exp_en.push_back(c0 + 9);
    exp_done.push_back(c0 + 14);
    @(negedge io_clk);
    bus.abort = 1'b0;
    wait_cyc(c0 + 13);
    bus.start = 1'b0;
    wait_cyc(c0 + 15);
    chk("rs_idle", bus.busy, 0);
    chk("rs_sent", bus.pulses_sent, 2);
    chk("rs_abt",  bus.aborted, 0);
    wait_cyc(c0 + 20);
    check_drained("rs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
